// File: rtl/fu_pkg.sv
// fu_pkg: shared definitions for the integer functional unit.
//   - field widths and issue-word layout
//   - opcode encodings
//   - forward-bus packed struct shared with reservation stations and the ROB
//   - multiplier FSM state encoding (exposed for debug)
//   - combinational ALU helper for the single-cycle opcodes
package fu_pkg;

    localparam int OPC_W   = 4;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 16;
    localparam int ISSUE_W = OPC_W + TAG_W + 2 * DATA_W;  // 42
    localparam int FWD_W   = 1 + TAG_W + DATA_W;          // 23

    // Issue word: {opcode[41:38], rob[37:32], valA[31:16], valB[15:0]}
    localparam int OPC_LSB  = 38;
    localparam int ROB_LSB  = 32;
    localparam int VALA_LSB = 16;
    localparam int VALB_LSB = 0;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_AND = 4'd2;
    localparam opcode_t OP_OR  = 4'd3;
    localparam opcode_t OP_XOR = 4'd4;
    localparam opcode_t OP_SLL = 4'd5;
    localparam opcode_t OP_SRL = 4'd6;
    localparam opcode_t OP_MUL = 4'd7;

    // Forward-bus word: {valid[22], rob[21:16], value[15:0]}
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  rob;
        logic [DATA_W-1:0] value;
    } fwd_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,  // no multiply in flight
        MUL_RUN  = 2'd1,  // shift-add iterations in progress
        MUL_WAIT = 2'd2   // product final, waiting for buffer space
    } mul_state_t;

    // Single-cycle result. MUL is handled by the multiplier; opcodes 8-15
    // produce zero but are still broadcast with their tag.
    function automatic logic [DATA_W-1:0] alu_result(input opcode_t opc,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (opc)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[3:0];
            OP_SRL:  r = a >> b[3:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/functional_unit_if.sv
// functional_unit_if: issue port plus common-data-bus forward channel.
//   op_valid/op_data/op_ready : issue handshake
//   flush                     : squash all in-flight work
//   fwd_out/fwd_grant         : forward-bus word and arbiter grant
//   dbg_mul_state             : multiplier FSM state (debug visibility)
// Handshakes: an operation transfers on a posedge where op_valid && op_ready;
// a forward word transfers on a posedge where fwd_out.valid && fwd_grant.
// op_valid must not depend on op_ready; op_ready never depends on fwd_grant.
interface functional_unit_if;
    import fu_pkg::*;

    logic               op_valid;
    logic [ISSUE_W-1:0] op_data;
    logic               op_ready;
    logic               flush;
    fwd_t               fwd_out;
    logic               fwd_grant;
    mul_state_t         dbg_mul_state;

    modport slave (
        input  op_valid, op_data, flush, fwd_grant,
        output op_ready, fwd_out, dbg_mul_state
    );

    modport master (
        output op_valid, op_data, flush, fwd_grant,
        input  op_ready, fwd_out, dbg_mul_state
    );

endinterface

// File: rtl/fu_multiplier.sv
// fu_multiplier: iterative shift-add multiplier, low DATA_W bits of a*b.
//   start    : load a, b, tag_i and begin ITERS iterations (ignored when busy)
//   hold     : result cannot be taken this edge; keep it until hold drops
//   flush    : drop any multiply in progress
//   busy     : a multiply is in flight (including a held result)
//   done     : product/tag_o are final and are consumed on this edge if !hold
//   state    : FSM state for debug
// The last iteration is folded into the done edge, so the product is pushed
// on the edge that takes the iteration count to zero.
module fu_multiplier
    import fu_pkg::*;
#(
    parameter int ITERS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              hold,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product,
    output logic [TAG_W-1:0]  tag_o,
    output mul_state_t        state
);

    localparam int ITER_W = $clog2(ITERS + 1);

    mul_state_t        state_q,  state_d;
    logic [ITER_W-1:0] iter_q,   iter_d;
    logic [DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [DATA_W-1:0] step_acc;

    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        tag_d    = tag_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d  = MUL_RUN;
                    iter_d   = ITER_W'(ITERS);
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    tag_d    = tag_i;
                end
            end
            MUL_RUN: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q - ITER_W'(1);
                if (iter_q == ITER_W'(1)) begin
                    state_d = hold ? MUL_WAIT : MUL_IDLE;
                end
            end
            MUL_WAIT: begin
                if (!hold) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
        if (flush) begin
            state_d = MUL_IDLE;
            iter_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            iter_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            tag_q    <= tag_d;
        end
    end

    assign busy    = (state_q != MUL_IDLE);
    assign done    = ((state_q == MUL_RUN) && (iter_q == ITER_W'(1))) || (state_q == MUL_WAIT);
    assign product = (state_q == MUL_WAIT) ? acc_q : step_acc;
    assign tag_o   = tag_q;
    assign state   = state_q;

endmodule

// File: rtl/functional_unit.sv
// functional_unit: integer execution unit behind a reservation-station port.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : functional_unit_if.slave (issue port, flush, forward channel)
// Single-cycle ALU results and iterative multiply results share a two-entry
// result buffer whose head is driven onto the forward bus. Only one push can
// happen per edge: ALU ops are only accepted while the multiplier is idle.
module functional_unit
    import fu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MUL_ITERS  = 16
) (
    input logic               clk,
    input logic               rst_n,
    functional_unit_if.slave  bus
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    opcode_t           opc;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;

    assign opc   = bus.op_data[OPC_LSB  +: OPC_W];
    assign rob   = bus.op_data[ROB_LSB  +: TAG_W];
    assign val_a = bus.op_data[VALA_LSB +: DATA_W];
    assign val_b = bus.op_data[VALB_LSB +: DATA_W];

    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [TAG_W-1:0]  mul_tag;
    mul_state_t        mul_state;

    logic [1:0] count_q, count_d;
    fwd_t       entry_q [2];
    fwd_t       entry_d [2];

    logic       op_ready;
    logic       accept;
    logic       is_mul;
    logic       pop;
    logic       room;
    logic       push_alu;
    logic       push_mul;
    logic       push;
    fwd_t       push_entry;
    logic [1:0] wr_slot;

    // Depends only on registered state, reset and flush -- never on grant.
    assign op_ready = rst_n && !mul_busy && (count_q < DEPTH) && !bus.flush;
    assign accept   = bus.op_valid && op_ready;
    assign is_mul   = (opc == OP_MUL);
    assign pop      = bus.fwd_grant && (count_q != 2'd0);
    // A pop on the same edge frees a slot for a completing multiply.
    assign room     = (count_q < DEPTH) || pop;
    assign push_alu = accept && !is_mul;
    assign push_mul = mul_done && room;
    assign push     = push_alu || push_mul;

    always_comb begin
        push_entry       = '0;
        push_entry.valid = 1'b1;
        if (push_mul) begin
            push_entry.rob   = mul_tag;
            push_entry.value = mul_product;
        end else begin
            push_entry.rob   = rob;
            push_entry.value = alu_result(opc, val_a, val_b);
        end
    end

    fu_multiplier #(
        .ITERS (MUL_ITERS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (val_a),
        .b       (val_b),
        .tag_i   (rob),
        .hold    (!room),
        .flush   (bus.flush),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product),
        .tag_o   (mul_tag),
        .state   (mul_state)
    );

    // Entry 0 is always the head; a pop shifts entry 1 forward and a push
    // lands in the first free slot after that shift.
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        wr_slot = pop ? (count_q - 2'd1) : count_q;
        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                entry_d[0] = entry_q[1];
            end
            if (push) begin
                if (wr_slot == 2'd0) begin
                    entry_d[0] = push_entry;
                end else begin
                    entry_d[1] = push_entry;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            entry_q <= '{default: '0};
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign bus.op_ready      = op_ready;
    assign bus.fwd_out       = (rst_n && (count_q != 2'd0)) ? entry_q[0] : '0;
    assign bus.dbg_mul_state = mul_state;

endmodule

// File: tb/tb_functional_unit.sv
// tb_functional_unit: directed and randomized stimulus for functional_unit,
// checked every cycle against a queue-based reference model.
module tb_functional_unit;
    import fu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    functional_unit_if bus ();

    functional_unit #(
        .FIFO_DEPTH (2),
        .MUL_ITERS  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending results in order, plus one outstanding multiply.
    logic [22:0] exp_q[$];
    bit          m_busy  = 1'b0;
    int          m_edge  = 0;
    logic [22:0] m_res   = '0;
    int          cyc     = 0;

    function automatic logic [15:0] ref_alu(input int opc, input int a, input int b);
        longint r;
        case (opc)
            0:       r = (a + b) % 65536;
            1:       r = (a - b + 65536) % 65536;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (longint'(a) * (longint'(1) << (b % 16))) % 65536;
            6:       r = a / (1 << (b % 16));
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Drive one cycle of inputs, check outputs against the model before the
    // edge, then advance the model across the edge.
    task automatic cycle(input logic v, input logic [3:0] opc, input logic [5:0] rob,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic fl, input logic g);
        logic        exp_ready;
        logic [22:0] exp_fwd;
        bus.op_valid  = v;
        bus.op_data   = {opc, rob, a, b};
        bus.flush     = fl;
        bus.fwd_grant = g;
        #1;
        exp_ready = rst_n && !m_busy && (exp_q.size() < 2) && !fl;
        exp_fwd   = (rst_n && exp_q.size() > 0) ? exp_q[0] : 23'h0;
        check("op_ready", {22'b0, bus.op_ready}, {22'b0, exp_ready});
        check("fwd_out", bus.fwd_out, exp_fwd);
        @(posedge clk);
        if (!rst_n || fl) begin
            exp_q.delete();
            m_busy = 1'b0;
        end else begin
            if (g && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_busy && cyc >= m_edge && exp_q.size() < 2) begin
                exp_q.push_back(m_res);
                m_busy = 1'b0;
            end
            if (v && exp_ready) begin
                if (opc == 4'd7) begin
                    m_busy = 1'b1;
                    m_edge = cyc + 16;
                    m_res  = {1'b1, rob, 16'((longint'(a) * longint'(b)) % 65536)};
                end else begin
                    exp_q.push_back({1'b1, rob, ref_alu(int'(opc), int'(a), int'(b))});
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic g);
        cycle(1'b0, 4'd0, 6'd0, 16'h0, 16'h0, 1'b0, g);
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_data   = '0;
        bus.flush     = 1'b0;
        bus.fwd_grant = 1'b0;

        // Reset, then ADD with 16-bit wrap past 0x7FFF.
        rst_n = 1'b0;
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;
        cycle(1'b1, 4'd0, 6'd5, 16'h7FFF, 16'h0002, 1'b0, 1'b0);
        check("add_result", bus.fwd_out, {1'b1, 6'd5, 16'h8001});
        idle(1'b1);
        check("add_popped", bus.fwd_out, 23'h0);

        // Back-to-back ALU ops fill the buffer.
        cycle(1'b1, 4'd1, 6'd1, 16'h0003, 16'h0005, 1'b0, 1'b0);
        cycle(1'b1, 4'd4, 6'd2, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
        check("full_head", bus.fwd_out, {1'b1, 6'd1, 16'hFFFE});
        check("full_ready", {22'b0, bus.op_ready}, 23'h0);
        cycle(1'b1, 4'd0, 6'd3, 16'h0001, 16'h0001, 1'b0, 1'b1);
        check("head_after_pop", bus.fwd_out, {1'b1, 6'd2, 16'hFF00});
        check("ready_after_pop", {22'b0, bus.op_ready}, 23'h1);
        cycle(1'b1, 4'd0, 6'd3, 16'h0001, 16'h0001, 1'b0, 1'b1);
        check("push_pop_same_edge", bus.fwd_out, {1'b1, 6'd3, 16'h0002});
        idle(1'b1);

        // Multiply: 300*300 = 90000 -> 0x5F90 after 16 edges.
        cycle(1'b1, 4'd7, 6'd9, 16'd300, 16'd300, 1'b0, 1'b0);
        check("mul_state_run", {21'b0, bus.dbg_mul_state}, {21'b0, MUL_RUN});
        for (int i = 0; i < 16; i++) idle(1'b0);
        check("mul_result", bus.fwd_out, {1'b1, 6'd9, 16'h5F90});
        check("mul_ready_again", {22'b0, bus.op_ready}, 23'h1);
        idle(1'b1);

        // Multiply issued after one pop lands behind the remaining entry.
        cycle(1'b1, 4'd0, 6'd10, 16'h0001, 16'h0001, 1'b0, 1'b0);
        cycle(1'b1, 4'd0, 6'd11, 16'h0002, 16'h0002, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 6'd12, 16'h1234, 16'h0011, 1'b0, 1'b1);
        cycle(1'b1, 4'd7, 6'd12, 16'h1234, 16'h0011, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) idle(1'b0);
        check("hold_head_stable", bus.fwd_out, {1'b1, 6'd11, 16'h0004});
        idle(1'b1);
        check("mul_behind", bus.fwd_out, {1'b1, 6'd12, 16'h3574});
        idle(1'b1);

        // Shift uses B[3:0]; illegal opcode broadcasts zero with its tag.
        cycle(1'b1, 4'd5, 6'd13, 16'h0001, 16'h0013, 1'b0, 1'b0);
        check("sll_result", bus.fwd_out, {1'b1, 6'd13, 16'h0008});
        cycle(1'b1, 4'd12, 6'd7, 16'hABCD, 16'h1111, 1'b0, 1'b1);
        check("illegal_opc", bus.fwd_out, {1'b1, 6'd7, 16'h0000});
        idle(1'b1);

        // Flush mid-multiply with a buffered result and a grant.
        cycle(1'b1, 4'd0, 6'd20, 16'h0005, 16'h0006, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 6'd21, 16'h0007, 16'h0008, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        cycle(1'b1, 4'd0, 6'd22, 16'h0001, 16'h0001, 1'b1, 1'b1);
        check("flush_fwd", bus.fwd_out, 23'h0);
        check("flush_mul_idle", {21'b0, bus.dbg_mul_state}, {21'b0, MUL_IDLE});
        for (int i = 0; i < 20; i++) idle(1'b1);
        check("no_mul_after_flush", bus.fwd_out, 23'h0);

        // Reset mid-multiply.
        cycle(1'b1, 4'd7, 6'd23, 16'h0003, 16'h0003, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) idle(1'b1);
        check("no_mul_after_reset", bus.fwd_out, 23'h0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] r_opc;
            rst_n = ($urandom_range(0, 299) != 0);
            r_opc = ($urandom_range(0, 9) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 99) < 70, r_opc, 6'($urandom_range(0, 63)),
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 99) < 60);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
